// File: rtl/nn_axil_pkg.sv
// Shared constants and types for the AXI4-Lite NN host blocks.
// Register map indices, CTRL/STATUS bit positions, loader FSM states.
package nn_axil_pkg;

  localparam logic [4:0] CTRL_IDX   = 5'd16;
  localparam logic [4:0] STATUS_IDX = 5'd17;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_SENT_LSB = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/axi4_lite_input_loader_if.sv
// AXI4-Lite slave bus plus the outgoing AXI-Stream of the input loader.
// master = host/consumer side, slave = loader side.
interface axi4_lite_input_loader_if;

  logic [6:0]  s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [6:0]  s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [31:0] x_tdata;
  logic        x_tvalid;
  logic        x_tready;
  logic        x_tlast;

  modport master (
    output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
    output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    output s_axil_bready,
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    output s_axil_rready,
    output x_tready,
    input  s_axil_awready, s_axil_wready,
    input  s_axil_bresp, s_axil_bvalid,
    input  s_axil_arready,
    input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  x_tdata, x_tvalid, x_tlast
  );

  modport slave (
    input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
    input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    input  s_axil_bready,
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
    input  s_axil_rready,
    input  x_tready,
    output s_axil_awready, s_axil_wready,
    output s_axil_bresp, s_axil_bvalid,
    output s_axil_arready,
    output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output x_tdata, x_tvalid, x_tlast
  );

endinterface

// File: rtl/axi4_lite_input_loader_regif.sv
// AXI4-Lite handshake engine: turns bus transfers into
// single-cycle wr_en/rd_en strobes with word indices.
module axil_slave_regif
  import nn_axil_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  axi4_lite_input_loader_if.slave bus,
  output logic        wr_en,
  output logic [4:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        rd_en,
  output logic [4:0]  rd_idx,
  input  logic [31:0] rd_data
);

  logic aw_go;
  logic ar_go;
  logic unused_bits;

  assign unused_bits = ^{bus.s_axil_awprot,
                         bus.s_axil_arprot,
                         bus.s_axil_awaddr[1:0],
                         bus.s_axil_araddr[1:0]};

  // Accept address+data together, one transfer per response.
  assign aw_go = bus.s_axil_awvalid
               & bus.s_axil_wvalid
               & ~bus.s_axil_bvalid
               & ~bus.s_axil_awready;

  assign ar_go = bus.s_axil_arvalid
               & ~bus.s_axil_rvalid
               & ~bus.s_axil_arready;

  // The ready pulse marks the cycle the transfer completes.
  assign wr_en   = bus.s_axil_awready;
  assign wr_idx  = bus.s_axil_awaddr[6:2];
  assign wr_data = bus.s_axil_wdata;
  assign wr_strb = bus.s_axil_wstrb;
  assign rd_en   = bus.s_axil_arready;
  assign rd_idx  = bus.s_axil_araddr[6:2];

  assign bus.s_axil_bresp = RESP_OKAY;
  assign bus.s_axil_rresp = RESP_OKAY;

  // Write channel: ready pulse, then hold response until taken.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus.s_axil_awready <= 1'b0;
      bus.s_axil_wready  <= 1'b0;
      bus.s_axil_bvalid  <= 1'b0;
    end else begin
      bus.s_axil_awready <= aw_go;
      bus.s_axil_wready  <= aw_go;
      if (wr_en)
        bus.s_axil_bvalid <= 1'b1;
      else if (bus.s_axil_bready)
        bus.s_axil_bvalid <= 1'b0;
    end
  end

  // Read channel: ready pulse, registered data held until taken.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus.s_axil_arready <= 1'b0;
      bus.s_axil_rvalid  <= 1'b0;
      bus.s_axil_rdata   <= '0;
    end else begin
      bus.s_axil_arready <= ar_go;
      if (rd_en) begin
        bus.s_axil_rvalid <= 1'b1;
        bus.s_axil_rdata  <= rd_data;
      end else if (bus.s_axil_rready) begin
        bus.s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_input_loader.sv
// Host-written input buffer streamed out to layer 0 on START.
// Define INPUT_LOADER_READBACK_EN to make BUF readable over AXI.
module axi4_lite_input_loader
  import nn_axil_pkg::*;
#(
  parameter int N_WORDS = 10
) (
  input  logic aclk,
  input  logic aresetn,
  axi4_lite_input_loader_if.slave bus,
  output logic done
);

  localparam logic [4:0] LAST = 5'(N_WORDS - 1);
  localparam logic [4:0] NW   = 5'(N_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  idx_q;
  logic [4:0]  sent_q;
  logic        err_q;
  logic [31:0] mem_q [N_WORDS];

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_en;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic [31:0] rd_buf;
  logic [31:0] status;
  logic [31:0] tdata_sel;

  logic busy;
  logic beat;
  logic last;
  logic ctrl_wr;
  logic start_cmd;
  logic clear_cmd;
  logic buf_wr;
  logic start_go;
  logic unused_rd;

  axil_slave_regif u_regif (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Read data is latched by the regif; the strobe is not needed here.
  assign unused_rd = rd_en;

  assign beat      = busy & bus.x_tready;
  assign last      = (idx_q == LAST);
  assign ctrl_wr   = wr_en & (wr_idx == CTRL_IDX) & wr_strb[0];
  assign start_cmd = ctrl_wr & wr_data[CTRL_START_BIT];
  assign clear_cmd = ctrl_wr & wr_data[CTRL_CLEAR_BIT];
  assign buf_wr    = wr_en & (wr_idx < NW);
  assign start_go  = start_cmd & ~busy;

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state; CLEAR+START from DONE restarts the stream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_cmd) state_d = STREAM;
      STREAM:
        if (beat && last) state_d = DONE;
      DONE:
        if (start_cmd)      state_d = STREAM;
        else if (clear_cmd) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // FSM outputs: stream valid while STREAM, done while DONE.
  always_comb begin
    busy         = (state_q == STREAM);
    done         = (state_q == DONE);
    bus.x_tvalid = busy;
    bus.x_tlast  = busy & last;
    bus.x_tdata  = busy ? tdata_sel : '0;
  end

  // Select the buffer word at the stream pointer.
  always_comb begin
    tdata_sel = '0;
    for (int i = 0; i < N_WORDS; i++)
      if (idx_q == 5'(i)) tdata_sel = mem_q[i];
  end

  // Stream pointer, sent counter and error flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx_q  <= '0;
      sent_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_go) begin
        idx_q  <= '0;
        sent_q <= '0;
      end else if (beat) begin
        idx_q <= last ? '0 : idx_q + 5'd1;
        if (sent_q != NW) sent_q <= sent_q + 5'd1;
      end
      if (clear_cmd)
        err_q <= 1'b0;
      if (busy && (start_cmd || buf_wr))
        err_q <= 1'b1;
    end
  end

  // Buffer: byte-enabled writes, frozen while streaming.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_WORDS; i++)
        mem_q[i] <= '0;
    end else if (buf_wr && !busy) begin
      for (int i = 0; i < N_WORDS; i++)
        if (wr_idx == 5'(i))
          for (int b = 0; b < 4; b++)
            if (wr_strb[b])
              mem_q[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // STATUS word assembly.
  always_comb begin
    status                      = '0;
    status[ST_BUSY_BIT]         = busy;
    status[ST_DONE_BIT]         = done;
    status[ST_ERR_BIT]          = err_q;
    status[ST_SENT_LSB +: 5]    = sent_q;
  end

  // Read decode; CTRL and unmapped indices read as zero.
  always_comb begin
    rd_buf = '0;
`ifdef INPUT_LOADER_READBACK_EN
    for (int i = 0; i < N_WORDS; i++)
      if (rd_idx == 5'(i)) rd_buf = mem_q[i];
`endif
    rd_data = '0;
    unique case (1'b1)
      (rd_idx == STATUS_IDX): rd_data = status;
      (rd_idx < NW):          rd_data = rd_buf;
      default:                rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_input_loader.sv
// Directed bench for axi4_lite_input_loader.
// Build with +define+INPUT_LOADER_READBACK_EN for the readback variant.
module tb_axi4_lite_input_loader;

  logic aclk = 1'b0;
  logic aresetn;
  logic done;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_buf [10];
  logic [31:0] rv;
  logic [31:0] exp_rb;
  int   k;
  int   cyc;
  int   n;

  axi4_lite_input_loader_if bus ();

  axi4_lite_input_loader #(.N_WORDS(10)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave),
    .done    (done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [4:0]  idx,
                    input logic [31:0] d,
                    input logic [3:0]  s);
    int w = 0;
    bus.s_axil_awaddr  = {idx, 2'b00};
    bus.s_axil_wdata   = d;
    bus.s_axil_wstrb   = s;
    bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wvalid  = 1'b1;
    while (!bus.s_axil_awready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.s_axil_awready)
      check("aw_timeout", 32'(bus.s_axil_awready), 1);
    tick();
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wvalid  = 1'b0;
    check("bvalid", 32'(bus.s_axil_bvalid), 1);
  endtask

  task automatic rd(input logic [4:0] idx, output logic [31:0] d);
    int w = 0;
    bus.s_axil_araddr  = {idx, 2'b00};
    bus.s_axil_arvalid = 1'b1;
    while (!bus.s_axil_arready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.s_axil_arready)
      check("ar_timeout", 32'(bus.s_axil_arready), 1);
    tick();
    bus.s_axil_arvalid = 1'b0;
    check("rvalid", 32'(bus.s_axil_rvalid), 1);
    d = bus.s_axil_rdata;
    tick();
  endtask

  // Assumes word 0 is on the bus now and x_tready is held high.
  task automatic stream_chk(input string tag);
    for (int j = 0; j < 10; j++) begin
      check({tag, "_tvalid"}, 32'(bus.x_tvalid), 1);
      check({tag, "_tdata"}, bus.x_tdata, exp_buf[j]);
      check({tag, "_tlast"}, 32'(bus.x_tlast), 32'(j == 9));
      tick();
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_tvalid_off"}, 32'(bus.x_tvalid), 0);
  endtask

  initial begin
    aresetn            = 1'b0;
    bus.s_axil_awaddr  = '0;
    bus.s_axil_awprot  = '0;
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wdata   = '0;
    bus.s_axil_wstrb   = '0;
    bus.s_axil_wvalid  = 1'b0;
    bus.s_axil_bready  = 1'b1;
    bus.s_axil_araddr  = '0;
    bus.s_axil_arprot  = '0;
    bus.s_axil_arvalid = 1'b0;
    bus.s_axil_rready  = 1'b1;
    bus.x_tready       = 1'b0;
    for (int i = 0; i < 10; i++) exp_buf[i] = '0;
    tick();
    tick();
    tick();

    check("rst_awready", 32'(bus.s_axil_awready), 0);
    check("rst_wready", 32'(bus.s_axil_wready), 0);
    check("rst_bvalid", 32'(bus.s_axil_bvalid), 0);
    check("rst_arready", 32'(bus.s_axil_arready), 0);
    check("rst_rvalid", 32'(bus.s_axil_rvalid), 0);
    check("rst_rdata", bus.s_axil_rdata, 0);
    check("rst_tvalid", 32'(bus.x_tvalid), 0);
    check("rst_tdata", bus.x_tdata, 0);
    check("rst_tlast", 32'(bus.x_tlast), 0);
    check("rst_done", 32'(done), 0);
    aresetn = 1'b1;
    tick();

    // Fill buffer and stream at full rate.
    for (int i = 0; i < 10; i++) begin
      exp_buf[i] = 32'h100 + 32'(i);
      wr(5'(i), exp_buf[i], 4'hF);
    end
    check("bresp", 32'(bus.s_axil_bresp), 0);
    bus.x_tready = 1'b1;
    wr(5'd16, 32'h1, 4'h1);
    stream_chk("full");
    rd(5'd17, rv);
    check("status_done", rv, 32'h0000_0A02);
    check("rresp", 32'(bus.s_axil_rresp), 0);

    // Same stream with alternating backpressure.
    bus.x_tready = 1'b0;
    wr(5'd16, 32'h1, 4'h1);
    k   = 0;
    cyc = 0;
    while (k < 10 && cyc < 60) begin
      bus.x_tready = (cyc % 2 == 0);
      check("stall_tvalid", 32'(bus.x_tvalid), 1);
      check("stall_tdata", bus.x_tdata, exp_buf[k]);
      check("stall_tlast", 32'(bus.x_tlast), 32'(k == 9));
      tick();
      if (bus.x_tready) k++;
      cyc++;
    end
    check("stall_count", 32'(k), 10);
    check("stall_done", 32'(done), 1);
    rd(5'd17, rv);
    check("stall_status", rv, 32'h0000_0A02);

    // START and BUF write while busy are dropped and flag err.
    bus.x_tready = 1'b0;
    wr(5'd16, 32'h1, 4'h1);
    wr(5'd16, 32'h1, 4'h1);
    wr(5'd3, 32'hDEAD_BEEF, 4'hF);
    rd(5'd17, rv);
    check("busy_err_status", rv, 32'h0000_0005);
    bus.x_tready = 1'b1;
    stream_chk("busy");
    rd(5'd17, rv);
    check("err_done_status", rv, 32'h0000_0A06);
    wr(5'd16, 32'h2, 4'h1);
    rd(5'd17, rv);
    check("clear_status", rv, 32'h0000_0A00);
    check("clear_done", 32'(done), 0);
    wr(5'd16, 32'h1, 4'h2);
    tick();
    check("ctrl_nostrb", 32'(bus.x_tvalid), 0);

    // Byte strobes, readback and unmapped reads.
    wr(5'd2, 32'hFFFF_FFFF, 4'hF);
    wr(5'd2, 32'h0000_0012, 4'h1);
    exp_buf[2] = 32'hFFFF_FF12;
`ifdef INPUT_LOADER_READBACK_EN
    exp_rb = 32'hFFFF_FF12;
`else
    exp_rb = 32'h0;
`endif
    rd(5'd2, rv);
    check("readback", rv, exp_rb);
    rd(5'd16, rv);
    check("ctrl_read", rv, 0);
    rd(5'd20, rv);
    check("unmapped_read", rv, 0);
    wr(5'd20, 32'h1234_5678, 4'hF);

    // START+CLEAR from IDLE, then again from DONE.
    wr(5'd16, 32'h3, 4'h1);
    stream_chk("sc_idle");
    wr(5'd16, 32'h3, 4'h1);
    stream_chk("sc_done");
    rd(5'd17, rv);
    check("sc_status", rv, 32'h0000_0A02);

    // Reset in the middle of a stream.
    wr(5'd16, 32'h1, 4'h1);
    tick();
    tick();
    tick();
    tick();
    check("mid_word4", bus.x_tdata, exp_buf[4]);
    aresetn = 1'b0;
    tick();
    check("mrst_tvalid", 32'(bus.x_tvalid), 0);
    check("mrst_tdata", bus.x_tdata, 0);
    check("mrst_tlast", 32'(bus.x_tlast), 0);
    check("mrst_done", 32'(done), 0);
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) exp_buf[i] = '0;
    rd(5'd17, rv);
    check("mrst_status", rv, 0);
    rd(5'd0, rv);
    check("mrst_buf0", rv, 0);
    wr(5'd16, 32'h1, 4'h1);
    stream_chk("zero");

    // Response held back: no new accept until bready.
    bus.s_axil_bready  = 1'b0;
    bus.s_axil_awaddr  = {5'd0, 2'b00};
    bus.s_axil_wdata   = 32'h55;
    bus.s_axil_wstrb   = 4'hF;
    bus.s_axil_awvalid = 1'b1;
    bus.s_axil_wvalid  = 1'b1;
    n = 0;
    while (!bus.s_axil_awready && n < 20) begin
      tick();
      n++;
    end
    check("bp_aw1", 32'(bus.s_axil_awready), 1);
    tick();
    bus.s_axil_awaddr = {5'd1, 2'b00};
    bus.s_axil_wdata  = 32'h66;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(bus.s_axil_bvalid), 1);
      check("bp_awready", 32'(bus.s_axil_awready), 0);
      check("bp_wready", 32'(bus.s_axil_wready), 0);
      tick();
    end
    bus.s_axil_bready = 1'b1;
    n = 0;
    while (!bus.s_axil_awready && n < 20) begin
      tick();
      n++;
    end
    check("bp_aw2", 32'(bus.s_axil_awready), 1);
    tick();
    bus.s_axil_awvalid = 1'b0;
    bus.s_axil_wvalid  = 1'b0;
    check("bp_bvalid2", 32'(bus.s_axil_bvalid), 1);
    tick();
    check("bp_bclear", 32'(bus.s_axil_bvalid), 0);
    exp_buf[0] = 32'h55;
    exp_buf[1] = 32'h66;
    wr(5'd16, 32'h1, 4'h1);
    stream_chk("bp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
